// File: rtl/compound_accumulator.sv
// compound_accumulator: sums signed frames from an upstream producer and emits
// one result per closed section. A section closes on a frame whose y flag is
// set, or when the frame count reaches m_limit (m_limit = 0 disables the
// limit). The block then holds the result until downstream accepts it.
//
// b_in carries the compound frame packed as {x, y}: x occupies bits
// [DATA_W:1] and y is bit 0.
module compound_accumulator #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W:0]   b_in,
  input  logic              b_in_sync,
  output logic              b_in_notify,
  output logic [DATA_W-1:0] r_out,
  input  logic              r_out_sync,
  output logic              r_out_notify,
  input  logic [CNT_W-1:0]  m_limit,
  output logic [CNT_W-1:0]  cnt_out
);

  typedef struct packed {
    logic signed [DATA_W-1:0] x;
    logic                     y;
  } compound_t;

  typedef enum logic [0:0] {
    SECTION_READ  = 1'b0,
    SECTION_WRITE = 1'b1
  } state_t;

  compound_t frame;
  assign frame = compound_t'(b_in);

  // Registered state
  state_t            state;
  logic [DATA_W-1:0] sum;
  logic [CNT_W-1:0]  cnt;

  // Next-state values
  state_t            state_n;
  logic [DATA_W-1:0] sum_n;
  logic [CNT_W-1:0]  cnt_n;
  logic [DATA_W-1:0] r_out_n;
  logic              r_out_notify_n;
  logic              b_in_notify_n;
  logic [CNT_W-1:0]  cnt_out_n;

  // Candidate values for an accepted frame; wrap-around is intentional.
  logic [DATA_W-1:0] sum_acc;
  logic [CNT_W-1:0]  cnt_acc;
  logic              close;

  assign sum_acc = sum + frame.x;
  assign cnt_acc = cnt + CNT_W'(1);
  assign close   = frame.y || ((m_limit != '0) && (cnt_acc >= m_limit));

  // Next-state and registered-output decode for the two-section handshake.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_n        = state;
    sum_n          = sum;
    cnt_n          = cnt;
    r_out_n        = r_out;
    r_out_notify_n = r_out_notify;
    b_in_notify_n  = b_in_notify;
    cnt_out_n      = cnt_out;

    unique case (state)
      SECTION_READ: begin
        if (b_in_sync) begin
          if (close) begin
            r_out_n        = sum_acc;
            r_out_notify_n = 1'b1;
            b_in_notify_n  = 1'b0;
            sum_n          = '0;
            cnt_n          = '0;
            state_n        = SECTION_WRITE;
          end else begin
            sum_n = sum_acc;
            cnt_n = cnt_acc;
          end
        end
      end
      SECTION_WRITE: begin
        // Upstream is ignored here; only the downstream accept moves us on.
        if (r_out_sync) begin
          r_out_notify_n = 1'b0;
          b_in_notify_n  = 1'b1;
          cnt_out_n      = cnt_out + CNT_W'(1);
          state_n        = SECTION_READ;
        end
      end
      default: state_n = SECTION_READ;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state        <= SECTION_READ;
      sum          <= '0;
      cnt          <= '0;
      r_out        <= '0;
      r_out_notify <= 1'b0;
      b_in_notify  <= 1'b1;
      cnt_out      <= '0;
    end else begin
      state        <= state_n;
      sum          <= sum_n;
      cnt          <= cnt_n;
      r_out        <= r_out_n;
      r_out_notify <= r_out_notify_n;
      b_in_notify  <= b_in_notify_n;
      cnt_out      <= cnt_out_n;
    end
  end

endmodule

// File: tb/tb_compound_accumulator.sv
// Directed self-checking bench for compound_accumulator.
module tb_compound_accumulator;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W:0]   b_in;
  logic              b_in_sync;
  logic              b_in_notify;
  logic [DATA_W-1:0] r_out;
  logic              r_out_sync;
  logic              r_out_notify;
  logic [CNT_W-1:0]  m_limit;
  logic [CNT_W-1:0]  cnt_out;

  int n_checks = 0;
  int n_fails  = 0;

  compound_accumulator #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .b_in         (b_in),
    .b_in_sync    (b_in_sync),
    .b_in_notify  (b_in_notify),
    .r_out        (r_out),
    .r_out_sync   (r_out_sync),
    .r_out_notify (r_out_notify),
    .m_limit      (m_limit),
    .cnt_out      (cnt_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] actual,
                       input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One clock edge; outputs are then sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] x, input logic y);
    b_in      = {x, y};
    b_in_sync = 1'b1;
    tick();
    b_in_sync = 1'b0;
  endtask

  task automatic deliver();
    r_out_sync = 1'b1;
    tick();
    r_out_sync = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // Hard time bound so the bench can never hang.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    b_in       = '0;
    b_in_sync  = 1'b0;
    r_out_sync = 1'b0;
    m_limit    = '0;
    rst        = 1'b1;
    #2;
    apply_reset();
    check("reset_b_in_notify", b_in_notify, 1);
    check("reset_r_out_notify", r_out_notify, 0);
    check("reset_r_out", r_out, 0);
    check("reset_cnt_out", cnt_out, 0);

    // Two frames, closed by y: 5 + 7.
    send(32'd5, 1'b0);
    check("acc_open_r_out_notify", r_out_notify, 0);
    check("acc_open_b_in_notify", b_in_notify, 1);
    send(32'd7, 1'b1);
    check("close_y_r_out", r_out, 12);
    check("close_y_r_out_notify", r_out_notify, 1);
    check("close_y_b_in_notify", b_in_notify, 0);
    deliver();
    check("deliver1_r_out_notify", r_out_notify, 0);
    check("deliver1_b_in_notify", b_in_notify, 1);
    check("deliver1_cnt_out", cnt_out, 1);
    check("deliver1_r_out_retained", r_out, 12);

    // Limit close on the third frame: 1 + 2 + 3.
    m_limit = 8'd3;
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    check("limit_second_no_close", r_out_notify, 0);
    send(32'd3, 1'b0);
    check("limit_r_out", r_out, 6);
    check("limit_r_out_notify", r_out_notify, 1);

    // Backpressure for 10 cycles while upstream keeps offering a frame.
    b_in      = {32'd100, 1'b1};
    b_in_sync = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_r_out", r_out, 6);
      check("bp_r_out_notify", r_out_notify, 1);
      check("bp_b_in_notify", b_in_notify, 0);
    end
    b_in_sync = 1'b0;
    deliver();
    check("limit_cnt_out", cnt_out, 2);
    check("limit_b_in_notify", b_in_notify, 1);
    // The refused frame must not have been added: sum still 0.
    m_limit = 8'd0;
    send(32'd4, 1'b1);
    check("bp_sum_clean", r_out, 4);
    deliver();
    check("bp_cnt_out", cnt_out, 3);

    // Modulo wrap of the sum.
    send(32'hFFFF_FFFF, 1'b0);
    send(32'd2, 1'b1);
    check("wrap_r_out", r_out, 1);
    deliver();
    check("wrap_cnt_out", cnt_out, 4);

    // Idle cycles with no transfer leave the sum untouched.
    send(32'd20, 1'b0);
    b_in = {32'd999, 1'b1};
    tick();
    tick();
    tick();
    check("idle_no_close", r_out_notify, 0);
    send(32'd9, 1'b1);
    check("idle_r_out", r_out, 29);
    deliver();
    check("idle_cnt_out", cnt_out, 5);

    // m_limit = 1 closes on every frame.
    m_limit = 8'd1;
    send(32'd3, 1'b0);
    check("limit1_r_out", r_out, 3);
    check("limit1_r_out_notify", r_out_notify, 1);
    deliver();
    check("limit1_cnt_out", cnt_out, 6);
    m_limit = 8'd0;

    // Reset mid-accumulation beats a coincident closing frame.
    send(32'd50, 1'b0);
    b_in      = {32'd1, 1'b1};
    b_in_sync = 1'b1;
    apply_reset();
    b_in_sync = 1'b0;
    check("rst_mid_r_out_notify", r_out_notify, 0);
    check("rst_mid_r_out", r_out, 0);
    check("rst_mid_cnt_out", cnt_out, 0);
    send(32'd2, 1'b1);
    check("rst_mid_sum_cleared", r_out, 2);
    deliver();
    check("rst_mid_cnt_out_after", cnt_out, 1);

    // Reset coincident with an output transfer discards the result.
    send(32'd8, 1'b1);
    check("rst_wr_pending", r_out_notify, 1);
    r_out_sync = 1'b1;
    apply_reset();
    r_out_sync = 1'b0;
    check("rst_wr_r_out", r_out, 0);
    check("rst_wr_r_out_notify", r_out_notify, 0);
    check("rst_wr_cnt_out", cnt_out, 0);
    check("rst_wr_b_in_notify", b_in_notify, 1);

    // m_limit = 0 with y = 0: 300 frames never close, internal count wraps.
    begin
      int closed = 0;
      for (int i = 0; i < 300; i++) begin
        send(32'd1, 1'b0);
        if (r_out_notify) closed++;
      end
      check("nolimit_never_closed", closed, 0);
    end
    send(32'd0, 1'b1);
    check("nolimit_r_out", r_out, 300);
    deliver();
    check("nolimit_cnt_out", cnt_out, 1);

    // Result counter wraps after 256 deliveries.
    for (int i = 0; i < 254; i++) begin
      send(32'd1, 1'b1);
      deliver();
    end
    check("cnt_out_255", cnt_out, 255);
    send(32'd1, 1'b1);
    deliver();
    check("cnt_out_wrap", cnt_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

endmodule
